// File: rtl/video_mem_wr_ctrl_if.sv
// Write-port bundle for video_mem_wr_ctrl. It carries the CPU and coprocessor
// write requests, the fill-engine controls and the video-memory write port.
//
// Handshake (cpu_* and cop_*): the requester raises *_req and holds *_addr and
// *_data stable. A write is accepted in the cycle where *_req && *_gnt. Only
// after that cycle may the requester change addr/data or drop req. A req may
// also be withdrawn before it is granted, and the write is then simply not made.
interface video_mem_wr_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_gnt;

  logic              cop_req;
  logic [ADDR_W-1:0] cop_addr;
  logic [DATA_W-1:0] cop_data;
  logic              cop_gnt;

  logic              fill_start;
  logic              fill_sel;
  logic [DATA_W-1:0] fill_color;
  logic              fill_busy;
  logic              fill_done;

  logic              vm_we;
  logic [ADDR_W-1:0] vm_waddr;
  logic [DATA_W-1:0] vm_wdata;

  // Requester side: the CPU, the coprocessor and whoever starts fills.
  modport master (
    output cpu_req, cpu_addr, cpu_data, input cpu_gnt,
    output cop_req, cop_addr, cop_data, input cop_gnt,
    output fill_start, fill_sel, fill_color, input fill_busy, fill_done,
    input  vm_we, vm_waddr, vm_wdata
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_addr, cpu_data, output cpu_gnt,
    input  cop_req, cop_addr, cop_data, output cop_gnt,
    input  fill_start, fill_sel, fill_color, output fill_busy, fill_done,
    output vm_we, vm_waddr, vm_wdata
  );
endinterface

// File: rtl/video_mem_wr_ctrl.sv
// video_mem_wr_ctrl: single write port of the video memory, shared between the
// CPU store path, the coprocessor output stream and a constant-colour fill
// engine. The port is granted round-robin, and a granted write appears on
// vm_* one cycle later.
// Build option VMEM_FILL_EN: when it is defined, the fill engine joins a 3-way
// round robin. When it is undefined, the fill inputs are ignored and the CPU
// and coprocessor share a 2-way round robin.
// dbg_state_o exposes the fill FSM state. It reads IDLE when the fill engine is
// absent.
module video_mem_wr_ctrl #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int IMG_PIXELS = 65536
) (
  input  logic               clk,
  input  logic               rst_n,
  video_mem_wr_ctrl_if.slave bus,
  output logic [1:0]         dbg_state_o
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_DONE = 2'd2} state_t;

  // Round-robin pointer value: the participant granted most recently.
  localparam logic [1:0] RR_CPU  = 2'd0;
  localparam logic [1:0] RR_COP  = 2'd1;
  localparam logic [1:0] RR_FILL = 2'd2;

  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              gnt_cpu, gnt_cop, gnt_fill;
  logic [1:0]        last_q, last_d;
  logic              vm_we_q, vm_we_d;
  logic [ADDR_W-1:0] vm_waddr_q, vm_waddr_d;
  logic [DATA_W-1:0] vm_wdata_q, vm_wdata_d;

  // Arbiter: the participant after the last winner has top priority, so the
  // last winner has the lowest. No grant is given while reset is held.
  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_cop  = 1'b0;
    gnt_fill = 1'b0;
    if (rst_n) begin
      case (last_q)
        RR_CPU: begin
          if (bus.cop_req)      gnt_cop  = 1'b1;
          else if (fill_req)    gnt_fill = 1'b1;
          else if (bus.cpu_req) gnt_cpu  = 1'b1;
        end
        RR_COP: begin
          if (fill_req)         gnt_fill = 1'b1;
          else if (bus.cpu_req) gnt_cpu  = 1'b1;
          else if (bus.cop_req) gnt_cop  = 1'b1;
        end
        default: begin
          if (bus.cpu_req)      gnt_cpu  = 1'b1;
          else if (bus.cop_req) gnt_cop  = 1'b1;
          else if (fill_req)    gnt_fill = 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_gnt = gnt_cpu;
  assign bus.cop_gnt = gnt_cop;

  // Pointer next state. The pointer moves only when a grant is given.
  always_comb begin
    last_d = last_q;
    if (gnt_cpu)       last_d = RR_CPU;
    else if (gnt_cop)  last_d = RR_COP;
    else if (gnt_fill) last_d = RR_FILL;
  end

  // Pointer register. Reset leaves FILL as the last winner, so the CPU is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= RR_FILL;
    else        last_q <= last_d;
  end

  // Write-port next state: load the winner's write, otherwise hold addr/data with we low.
  always_comb begin
    vm_we_d    = gnt_cpu | gnt_cop | gnt_fill;
    vm_waddr_d = vm_waddr_q;
    vm_wdata_d = vm_wdata_q;
    if (gnt_cpu) begin
      vm_waddr_d = bus.cpu_addr;
      vm_wdata_d = bus.cpu_data;
    end else if (gnt_cop) begin
      vm_waddr_d = bus.cop_addr;
      vm_wdata_d = bus.cop_data;
    end else if (gnt_fill) begin
      vm_waddr_d = fill_addr;
      vm_wdata_d = fill_data;
    end
  end

  // Registered video-memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vm_we_q    <= 1'b0;
      vm_waddr_q <= '0;
      vm_wdata_q <= '0;
    end else begin
      vm_we_q    <= vm_we_d;
      vm_waddr_q <= vm_waddr_d;
      vm_wdata_q <= vm_wdata_d;
    end
  end

  assign bus.vm_we    = vm_we_q;
  assign bus.vm_waddr = vm_waddr_q;
  assign bus.vm_wdata = vm_wdata_q;

`ifdef VMEM_FILL_EN
  localparam int                CNT_W      = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0] HALF1_BASE = ADDR_W'(IMG_PIXELS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] color_q, color_d;

  // Fill FSM next state. The count advances on each fill grant. The grant of
  // the last pixel moves the FSM to DONE, and the count then holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.fill_start) begin
          state_d = ST_FILL;
          base_d  = bus.fill_sel ? HALF1_BASE : '0;
          color_d = bus.fill_color;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (gnt_fill) begin
          if (cnt_q == CNT_LAST) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill FSM registers. Reset aborts a running fill at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      color_q <= color_d;
    end
  end

  assign fill_req      = (state_q == ST_FILL);
  assign fill_addr     = base_q + ADDR_W'(cnt_q);
  assign fill_data     = color_q;
  assign bus.fill_busy = (state_q == ST_FILL);
  assign bus.fill_done = (state_q == ST_DONE);
  assign dbg_state_o   = state_q;
`else
  logic unused_fill;
  assign unused_fill   = ^{bus.fill_start, bus.fill_sel, bus.fill_color};
  assign fill_req      = 1'b0;
  assign fill_addr     = '0;
  assign fill_data     = '0;
  assign bus.fill_busy = 1'b0;
  assign bus.fill_done = 1'b0;
  assign dbg_state_o   = ST_IDLE;
`endif
endmodule

// File: tb/tb_video_mem_wr_ctrl.sv
// Testbench for video_mem_wr_ctrl. A reduced image half keeps the fill runs
// short. The reference model predicts grants as "first requester after the
// last winner, modulo the number of participants". It holds fill progress as
// base plus index, and expected writes sit in a queue.
module tb_video_mem_wr_ctrl;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int IMG    = 256;
`ifdef VMEM_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam int NP = FILL_EN ? 3 : 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  video_mem_wr_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  video_mem_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_PIXELS(IMG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b0;

  // ---------------- reference model / scoreboard ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] m_addr_h;
  logic [DATA_W-1:0] m_data_h;
  int                m_last;
  bit                m_active, m_done;
  int                m_base, m_idx;
  logic [DATA_W-1:0] m_color;

  task automatic m_reset();
    exp_q.delete();
    m_addr_h = '0;
    m_data_h = '0;
    m_last   = NP - 1;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_base   = 0;
    m_idx    = 0;
    m_color  = '0;
  endtask

  // At each falling edge, check the registered port against the queue, check
  // the grants against the model's choice, then advance the model.
  always @(negedge clk) begin
    if (sb_en) begin
      if (!rst_n) begin
        n_tests++;
        if (bus.cpu_gnt !== 1'b0 || bus.cop_gnt !== 1'b0 || bus.vm_we !== 1'b0 ||
            bus.vm_waddr !== '0 || bus.vm_wdata !== '0 || bus.fill_busy !== 1'b0 ||
            bus.fill_done !== 1'b0) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL sb_reset: got gnt=%b%b we=%b addr=%h data=%h busy=%b done=%b, want all 0",
                     bus.cpu_gnt, bus.cop_gnt, bus.vm_we, bus.vm_waddr, bus.vm_wdata,
                     bus.fill_busy, bus.fill_done);
        end
        m_reset();
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        logic ew;
        bit [2:0] req;
        int w, p;
        bit was_active, was_done, fin;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          m_addr_h = e[ADDR_W+DATA_W-1:DATA_W];
          m_data_h = e[DATA_W-1:0];
          ew = 1'b1;
        end else begin
          ew = 1'b0;
        end
        n_tests++;
        if (bus.vm_we !== ew || bus.vm_waddr !== m_addr_h || bus.vm_wdata !== m_data_h) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL sb_vm: got we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                     bus.vm_we, bus.vm_waddr, bus.vm_wdata, ew, m_addr_h, m_data_h);
        end
        req = {m_active, bus.cop_req, bus.cpu_req};
        w = -1;
        for (int k = 1; k <= NP; k++) begin
          p = (m_last + k) % NP;
          if (w < 0 && req[p]) w = p;
        end
        n_tests++;
        if (bus.cpu_gnt !== (w == 0) || bus.cop_gnt !== (w == 1)) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL sb_gnt: got cpu=%b cop=%b, want winner %0d (req=%b last=%0d)",
                     bus.cpu_gnt, bus.cop_gnt, w, req, m_last);
        end
        n_tests++;
        if (bus.fill_busy !== m_active || bus.fill_done !== m_done) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL sb_fill: got busy=%b done=%b, want busy=%b done=%b",
                     bus.fill_busy, bus.fill_done, m_active, m_done);
        end
        was_active = m_active;
        was_done   = m_done;
        fin = 1'b0;
        if (w >= 0) begin
          m_last = w;
          if (w == 0)      exp_q.push_back({bus.cpu_addr, bus.cpu_data});
          else if (w == 1) exp_q.push_back({bus.cop_addr, bus.cop_data});
          else begin
            exp_q.push_back({ADDR_W'(m_base + m_idx), m_color});
            if (m_idx == IMG - 1) begin
              m_active = 1'b0;
              fin = 1'b1;
            end else begin
              m_idx++;
            end
          end
        end
        m_done = fin;
        if (FILL_EN && !was_active && !was_done && bus.fill_start === 1'b1) begin
          m_active = 1'b1;
          m_base   = bus.fill_sel ? IMG : 0;
          m_idx    = 0;
          m_color  = bus.fill_color;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.cpu_req    = 1'b0;
    bus.cop_req    = 1'b0;
    bus.fill_start = 1'b0;
  endtask

  task automatic drive_random(input int cycles, input bit allow_fill);
    logic gc, gp;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      gc = bus.cpu_gnt;
      gp = bus.cop_gnt;
      @(posedge clk); #1;
      if (!bus.cpu_req || gc) begin
        bus.cpu_req  = ($urandom_range(0, 3) != 0);
        bus.cpu_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        bus.cpu_data = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.cpu_req = 1'b0;
      end
      if (!bus.cop_req || gp) begin
        bus.cop_req  = ($urandom_range(0, 3) != 0);
        bus.cop_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        bus.cop_data = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.cop_req = 1'b0;
      end
      bus.fill_start = allow_fill && ($urandom_range(0, 199) == 0);
      bus.fill_sel   = 1'($urandom_range(0, 1));
      bus.fill_color = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_random(12, 1'b0);
    bus.cpu_req  = 1'b1; bus.cpu_addr = 17'h00123; bus.cpu_data = 12'h321;
    bus.cop_req  = 1'b1; bus.cop_addr = 17'h04567; bus.cop_data = 12'h765;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.cpu_gnt !== 1'b0 || bus.cop_gnt !== 1'b0 || bus.vm_we !== 1'b0 ||
        bus.vm_waddr !== '0 || bus.vm_wdata !== '0 || bus.fill_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got gnt=%b%b we=%b addr=%h data=%h busy=%b, want all 0",
               bus.cpu_gnt, bus.cop_gnt, bus.vm_we, bus.vm_waddr, bus.vm_wdata, bus.fill_busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      #1;
      n_tests++;
      if (bus.cpu_gnt !== (k % 2 == 0) || bus.cop_gnt !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_alternate[%0d]: got cpu=%b cop=%b, want cpu=%b cop=%b",
                 k, bus.cpu_gnt, bus.cop_gnt, (k % 2 == 0), (k % 2 == 1));
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 17'h00010; bus.cpu_data = 12'hABC;
    #1;
    n_tests++;
    if (bus.cpu_gnt !== 1'b1 || bus.cop_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt: got cpu=%b cop=%b, want cpu=1 cop=0", bus.cpu_gnt, bus.cop_gnt);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    n_tests++;
    if (bus.vm_we !== 1'b1 || bus.vm_waddr !== 17'h00010 || bus.vm_wdata !== 12'hABC) begin
      n_fail++;
      $display("FAIL single_write: got we=%b addr=%h data=%h, want we=1 addr=00010 data=abc",
               bus.vm_we, bus.vm_waddr, bus.vm_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.vm_we !== 1'b0 || bus.vm_waddr !== 17'h00010 || bus.vm_wdata !== 12'hABC) begin
      n_fail++;
      $display("FAIL single_idle: got we=%b addr=%h data=%h, want we=0 addr=00010 data=abc",
               bus.vm_we, bus.vm_waddr, bus.vm_wdata);
    end
  endtask

  task automatic test_fill();
    int writes = 0;
    int bad = 0;
    int cyc = 0;
    bit done_seen = 1'b0;
    logic [ADDR_W-1:0] done_addr = '0;
    logic done_we = 1'b0;
    @(posedge clk); #1;
    bus.fill_start = 1'b1; bus.fill_sel = 1'b1; bus.fill_color = 12'hF00;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    #1;
    n_tests++;
    if (bus.fill_busy !== FILL_EN) begin
      n_fail++;
      $display("FAIL fill_busy_start: got %b, want %b", bus.fill_busy, FILL_EN);
    end
    while (cyc < IMG + 20 && !done_seen) begin
      @(negedge clk);
      cyc++;
      if (bus.vm_we === 1'b1) begin
        if (bus.vm_waddr !== ADDR_W'(IMG + writes) || bus.vm_wdata !== 12'hF00) bad++;
        writes++;
      end
      if (bus.fill_done === 1'b1) begin
        done_seen = 1'b1;
        done_addr = bus.vm_waddr;
        done_we   = bus.vm_we;
      end
    end
    n_tests++;
    if (writes != (FILL_EN ? IMG : 0)) begin
      n_fail++;
      $display("FAIL fill_count: got %0d writes, want %0d", writes, FILL_EN ? IMG : 0);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fill_addr_seq: got %0d out-of-sequence writes, want 0", bad);
    end
    n_tests++;
    if (done_seen !== FILL_EN || done_we !== FILL_EN ||
        done_addr !== (FILL_EN ? ADDR_W'(2 * IMG - 1) : '0)) begin
      n_fail++;
      $display("FAIL fill_done_last: got seen=%b we=%b addr=%h, want seen=%b we=%b addr=%h",
               done_seen, done_we, done_addr, FILL_EN, FILL_EN,
               FILL_EN ? ADDR_W'(2 * IMG - 1) : ADDR_W'(0));
    end
    @(negedge clk);
    n_tests++;
    if (bus.fill_busy !== 1'b0 || bus.fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_after: got busy=%b done=%b, want 0 0", bus.fill_busy, bus.fill_done);
    end
  endtask

  task automatic test_fill_cop();
    int fill_w = 0;
    int cop_w = 0;
    int ff_pairs = 0;
    int bad_base = 0;
    int cyc = 0;
    bit prev_fill = 1'b0;
    bit done_seen = 1'b0;
    logic g;
    logic [DATA_W-1:0] color;
    color = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
    @(posedge clk); #1;
    bus.fill_start = 1'b1; bus.fill_sel = 1'b0; bus.fill_color = color;
    bus.cop_req  = 1'b1;
    bus.cop_addr = ADDR_W'($urandom_range(2 * IMG, (1 << ADDR_W) - 1));
    bus.cop_data = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    while (cyc < 2 * IMG + 40 && !done_seen) begin
      @(negedge clk);
      cyc++;
      g = bus.cop_gnt;
      if (bus.vm_we === 1'b1) begin
        if (int'(bus.vm_waddr) < 2 * IMG) begin
          fill_w++;
          if (int'(bus.vm_waddr) >= IMG || bus.vm_wdata !== color) bad_base++;
          if (prev_fill) ff_pairs++;
          prev_fill = 1'b1;
        end else begin
          cop_w++;
          prev_fill = 1'b0;
        end
      end
      if (bus.fill_done === 1'b1) done_seen = 1'b1;
      @(posedge clk); #1;
      bus.fill_start = (cyc == IMG / 2);
      bus.fill_sel   = 1'b1;
      if (g) begin
        bus.cop_addr = ADDR_W'($urandom_range(2 * IMG, (1 << ADDR_W) - 1));
        bus.cop_data = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      end
    end
    drive_idle();
    n_tests++;
    if (fill_w != (FILL_EN ? IMG : 0)) begin
      n_fail++;
      $display("FAIL fillcop_count: got %0d fill writes, want %0d", fill_w, FILL_EN ? IMG : 0);
    end
    n_tests++;
    if (bad_base != 0) begin
      n_fail++;
      $display("FAIL fillcop_base: got %0d writes outside half 0 or wrong colour, want 0", bad_base);
    end
    n_tests++;
    if (ff_pairs != 0 || cop_w < IMG - 1) begin
      n_fail++;
      $display("FAIL fillcop_alternate: got %0d fill-fill pairs and %0d cop writes, want 0 and >= %0d",
               ff_pairs, cop_w, IMG - 1);
    end
    n_tests++;
    if (done_seen !== FILL_EN) begin
      n_fail++;
      $display("FAIL fillcop_done: got %b, want %b", done_seen, FILL_EN);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_fill();
    int w = 0;
    int cyc = 0;
    bit got = 1'b0;
    bit done_seen = 1'b0;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [DATA_W-1:0] first_data = '0;
    logic [DATA_W-1:0] c2;
    c2 = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
    @(posedge clk); #1;
    bus.fill_start = 1'b1; bus.fill_sel = 1'b1; bus.fill_color = 12'h0F0;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    while (w < 100 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.vm_we === 1'b1) w++;
    end
    n_tests++;
    if ((w >= 100) !== FILL_EN) begin
      n_fail++;
      $display("FAIL midfill_progress: got %0d writes, want 100 reached=%b", w, FILL_EN);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.fill_busy !== 1'b0 || bus.fill_done !== 1'b0 || bus.vm_we !== 1'b0 ||
        dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midfill_abort: got busy=%b done=%b we=%b state=%0d, want 0 0 0 0",
               bus.fill_busy, bus.fill_done, bus.vm_we, dbg_state);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.fill_done !== 1'b0) done_seen = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.fill_done !== 1'b0) done_seen = 1'b1;
    n_tests++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL midfill_no_done: got fill_done pulse around reset, want none");
    end
    @(posedge clk); #1;
    bus.fill_start = 1'b1; bus.fill_sel = 1'b0; bus.fill_color = c2;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.vm_we === 1'b1) begin
        got = 1'b1;
        first_addr = bus.vm_waddr;
        first_data = bus.vm_wdata;
      end
    end
    n_tests++;
    if (got !== FILL_EN || first_addr !== '0 || first_data !== (FILL_EN ? c2 : '0)) begin
      n_fail++;
      $display("FAIL midfill_restart: got write=%b addr=%h data=%h, want write=%b addr=00000 data=%h",
               got, first_addr, first_data, FILL_EN, FILL_EN ? c2 : DATA_W'(0));
    end
    cyc = 0;
    while (bus.fill_busy === 1'b1 && cyc < IMG + 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (bus.fill_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_finish: got busy=%b after %0d cycles, want 0", bus.fill_busy, cyc);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    drive_random(3000, 1'b1);
    repeat (IMG + 10) @(posedge clk);
    n_tests++;
    if (bus.fill_busy !== 1'b0 || bus.vm_we !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got busy=%b we=%b, want 0 0", bus.fill_busy, bus.vm_we);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n          = 1'b0;
    bus.cpu_req    = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.cop_req    = 1'b0; bus.cop_addr = '0; bus.cop_data = '0;
    bus.fill_start = 1'b0; bus.fill_sel = 1'b0; bus.fill_color = '0;
    m_reset();
    sb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single();
    test_fill();
    test_fill_cop();
    test_reset_mid_fill();
    test_random();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
